// File: rtl/fmadd_sched_if.sv
// fmadd_sched_if: the bundle between the issue logic, the fmadd scheduler and
// the fmadd datapath.
//
// Request side (per requester i, operands packed at [32*i+31:32*i]):
//   req_valid[i]  requester i has an operation pending
//   req_ready[i]  one-hot grant from the scheduler
//   req_x/y/z     operands
// Datapath side:
//   fu_req        start pulse, fu_x/y/z operands, fu_rslt/fu_flag returned result
// Response side:
//   rsp_valid/rsp_ready handshake carrying rsp_id, rsp_rslt, rsp_flag
// Status:
//   busy, flag_clr, flag_acc (sticky {NV,DZ,OF,UF,NX}), dbg_state (FSM state)
//
// Handshake rule for both req_* and rsp_*: a transfer happens on a rising clock
// edge where valid and ready are both high; ready seen while valid is low has
// no effect, and the producer holds its payload stable until the transfer.
interface fmadd_sched_if #(
    parameter int NREQ = 4
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*32-1:0] req_x;
    logic [NREQ*32-1:0] req_y;
    logic [NREQ*32-1:0] req_z;

    logic               fu_req;
    logic [31:0]        fu_x;
    logic [31:0]        fu_y;
    logic [31:0]        fu_z;
    logic [31:0]        fu_rslt;
    logic [4:0]         fu_flag;

    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [31:0]        rsp_rslt;
    logic [4:0]         rsp_flag;

    logic               busy;
    logic               flag_clr;
    logic [4:0]         flag_acc;
    logic [2:0]         dbg_state;

    // Environment view: issue logic, fmadd datapath and response consumer.
    modport master (
        output req_valid, req_x, req_y, req_z,
        input  req_ready,
        input  fu_req, fu_x, fu_y, fu_z,
        output fu_rslt, fu_flag,
        input  rsp_valid, rsp_id, rsp_rslt, rsp_flag,
        output rsp_ready,
        output flag_clr,
        input  busy, flag_acc, dbg_state
    );

    // Scheduler view.
    modport slave (
        input  req_valid, req_x, req_y, req_z,
        output req_ready,
        output fu_req, fu_x, fu_y, fu_z,
        input  fu_rslt, fu_flag,
        output rsp_valid, rsp_id, rsp_rslt, rsp_flag,
        input  rsp_ready,
        input  flag_clr,
        output busy, flag_acc, dbg_state
    );
endinterface

// File: rtl/fmadd_sched.sv
// fmadd_sched: shares one multi-cycle fmadd unit among NREQ requesters.
// A round-robin arbiter grants one requester in IDLE and latches its operands;
// the FSM pulses fu_req, waits LAT edges, captures fu_rslt/fu_flag and offers
// them with the requester id on the response handshake. flag_acc keeps the
// sticky OR of every captured flag vector.
//
// Ports:
//   clk    clock, all state on the rising edge
//   reset  asynchronous active-low reset
//   bus    fmadd_sched_if.slave (request, datapath, response and status signals)
module fmadd_sched #(
    parameter int NREQ = 4,
    parameter int LAT  = 6
) (
    input logic          clk,
    input logic          reset,
    fmadd_sched_if.slave bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW  = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        RUN   = 3'd2,
        CAPT  = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [IDW-1:0] rr_ptr;

    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] cand;
    logic           grant_any;
    logic [NREQ-1:0] grant_oh;
    logic [31:0]    sel_x;
    logic [31:0]    sel_y;
    logic [31:0]    sel_z;

    // Round-robin search: start one past the last granted index and wrap, so
    // the most recently served requester has the lowest priority.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(rr_ptr) + k) % NREQ);
            if (!grant_any && bus.req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign grant_oh = NREQ'(1) << grant_idx;

    // Grant is offered only while idle and out of reset, so every output is
    // zero while reset is held even if requests are pending.
    assign bus.req_ready = (state == IDLE && reset && grant_any) ? grant_oh : '0;

    assign sel_x = bus.req_x[32*grant_idx +: 32];
    assign sel_y = bus.req_y[32*grant_idx +: 32];
    assign sel_z = bus.req_z[32*grant_idx +: 32];

    assign bus.dbg_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            rr_ptr        <= IDW'(NREQ - 1);
            bus.fu_req    <= 1'b0;
            bus.fu_x      <= '0;
            bus.fu_y      <= '0;
            bus.fu_z      <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_rslt  <= '0;
            bus.rsp_flag  <= '0;
            bus.busy      <= 1'b0;
            bus.flag_acc  <= '0;
        end else begin
            // A clear outside CAPT wins; CAPT overrides below so the flags
            // captured on that edge survive a simultaneous clear.
            if (bus.flag_clr) begin
                bus.flag_acc <= '0;
            end
            unique case (state)
                IDLE: begin
                    if (grant_any) begin
                        bus.fu_x   <= sel_x;
                        bus.fu_y   <= sel_y;
                        bus.fu_z   <= sel_z;
                        bus.rsp_id <= grant_idx;
                        rr_ptr     <= grant_idx;
                        bus.fu_req <= 1'b1;
                        bus.busy   <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.fu_req <= 1'b0;
                    cnt        <= '0;
                    state      <= RUN;
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(LAT - 1)) begin
                        state <= CAPT;
                    end
                end
                CAPT: begin
                    bus.rsp_rslt  <= bus.fu_rslt;
                    bus.rsp_flag  <= bus.fu_flag;
                    bus.rsp_valid <= 1'b1;
                    bus.flag_acc  <= (bus.flag_clr ? 5'd0 : bus.flag_acc) | bus.fu_flag;
                    state         <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fmadd_sched.sv
module tb_fmadd_sched;
    localparam int NREQ = 4;
    localparam int LAT  = 6;
    localparam int IDW  = 2;
    localparam int W    = IDW + 37;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fmadd_sched_if #(.NREQ(NREQ)) bus();

    fmadd_sched #(.NREQ(NREQ), .LAT(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- fmadd reference results ----------------
    function automatic logic [36:0] fma_ref(input logic [31:0] x, input logic [31:0] y,
                                            input logic [31:0] z);
        case ({x, y, z})
            {32'h3FC00000, 32'h40000000, 32'h3E800000}: return {32'h40500000, 5'b00000};
            {32'h7F800000, 32'h00000000, 32'h00000000}: return {32'hFFC00000, 5'b10000};
            {32'h7F000000, 32'h7F000000, 32'h00000000}: return {32'h7F800000, 5'b00101};
            {32'h40000000, 32'h3F800000, 32'h00000000}: return {32'h40000000, 5'b00000};
            {32'h40000000, 32'h40000000, 32'h00000000}: return {32'h40800000, 5'b00000};
            {32'h40000000, 32'h40400000, 32'h00000000}: return {32'h40C00000, 5'b00000};
            {32'h40000000, 32'h40800000, 32'h00000000}: return {32'h41000000, 5'b00000};
            default: return {x ^ y ^ z, x[4:0]};
        endcase
    endfunction

    // fmadd datapath stand-in: result valid exactly LAT edges after the fu_req edge
    int fu_cnt;
    always @(posedge clk or negedge reset) begin
        if (!reset) fu_cnt <= -1;
        else if (bus.fu_req) fu_cnt <= 0;
        else if (fu_cnt >= 0 && fu_cnt < LAT) fu_cnt <= fu_cnt + 1;
        else fu_cnt <= -1;
    end
    logic [36:0] fu_val;
    assign fu_val      = fma_ref(bus.fu_x, bus.fu_y, bus.fu_z);
    assign bus.fu_rslt = (fu_cnt == LAT) ? fu_val[36:5] : 32'hDEADBEEF;
    assign bus.fu_flag = (fu_cnt == LAT) ? fu_val[4:0] : 5'b11111;

    // ---------------- behavioural model + scoreboard ----------------
    logic [W-1:0]   exp_q[$];
    logic           busy_m, acc_next, hs_next;
    int             d_m;           // edges since the accept edge (0 = just accepted)
    logic [IDW-1:0] rr_m, gnt_m;
    logic [31:0]    fx_m, fy_m, fz_m, nx, ny, nz;
    logic [4:0]     acc_m, acc_nx;

    function automatic void model_reset();
        busy_m   = 1'b0;
        acc_next = 1'b0;
        hs_next  = 1'b0;
        d_m      = 0;
        rr_m     = IDW'(NREQ - 1);
        gnt_m    = '0;
        fx_m = '0; fy_m = '0; fz_m = '0;
        nx = '0; ny = '0; nz = '0;
        acc_m  = '0;
        acc_nx = '0;
        exp_q.delete();
    endfunction

    always @(negedge clk) begin : cmp
        logic [IDW-1:0]  g;
        logic            gv;
        logic [NREQ-1:0] exp_rdy;
        logic [W-1:0]    hd;
        if (reset) begin
            // apply what the model decided would happen on the edge just passed
            if (hs_next) begin
                busy_m  = 1'b0;
                void'(exp_q.pop_front());
                hs_next = 1'b0;
            end
            if (acc_next) begin
                busy_m   = 1'b1;
                d_m      = 0;
                rr_m     = gnt_m;
                fx_m = nx; fy_m = ny; fz_m = nz;
                acc_next = 1'b0;
            end else if (busy_m) begin
                d_m++;
            end
            acc_m = acc_nx;

            gv = 1'b0;
            g  = '0;
            for (int k = 1; k <= NREQ; k++) begin
                if (!gv && bus.req_valid[(int'(rr_m) + k) % NREQ]) begin
                    gv = 1'b1;
                    g  = IDW'((int'(rr_m) + k) % NREQ);
                end
            end
            exp_rdy = (!busy_m && gv) ? (NREQ'(1) << g) : '0;

            chk("req_ready", bus.req_ready, exp_rdy);
            chk("busy", bus.busy, busy_m);
            chk("fu_req", bus.fu_req, busy_m && d_m == 0);
            chk("fu_x", bus.fu_x, fx_m);
            chk("fu_y", bus.fu_y, fy_m);
            chk("fu_z", bus.fu_z, fz_m);
            chk("rsp_valid", bus.rsp_valid, busy_m && d_m >= 8);
            chk("flag_acc", bus.flag_acc, acc_m);
            if (busy_m && exp_q.size() == 0) chk("exp_q_empty", 1, 0);
            if (busy_m && d_m >= 8 && exp_q.size() != 0) begin
                hd = exp_q[0];
                chk("rsp_id", bus.rsp_id, hd[W-1:37]);
                chk("rsp_rslt", bus.rsp_rslt, hd[36:5]);
                chk("rsp_flag", bus.rsp_flag, hd[4:0]);
            end

            // decide what the coming edge does
            if (exp_rdy != '0) begin
                acc_next = 1'b1;
                gnt_m    = g;
                nx = bus.req_x[32*g +: 32];
                ny = bus.req_y[32*g +: 32];
                nz = bus.req_z[32*g +: 32];
                exp_q.push_back({g, fma_ref(nx, ny, nz)});
            end
            if (busy_m && d_m == 7 && exp_q.size() != 0) begin
                hd     = exp_q[0];
                acc_nx = (bus.flag_clr ? 5'd0 : acc_m) | hd[4:0];
            end else begin
                acc_nx = bus.flag_clr ? 5'd0 : acc_m;
            end
            if (busy_m && d_m >= 8 && bus.rsp_ready) hs_next = 1'b1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        repeat (3) tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic load(input int p, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] z);
        bus.req_x[32*p +: 32] = x;
        bus.req_y[32*p +: 32] = y;
        bus.req_z[32*p +: 32] = z;
    endtask

    // returns at accept edge + 1
    task automatic wait_accept(input int p);
        logic ok;
        ok = 1'b0;
        bus.req_valid[p] = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (bus.req_ready[p] && bus.req_valid[p]) ok = 1'b1;
        end
        tick();
        bus.req_valid[p] = 1'b0;
        chk("accept_seen", ok, 1'b1);
    endtask

    // n counts edges with the accept edge as 1; flag_clr is high after edge clr_at
    task automatic wait_rsp(input int clr_at, output int n);
        n = 1;
        while (!bus.rsp_valid && n < 40) begin
            tick();
            n++;
            bus.flag_clr = (n == clr_at);
        end
        bus.flag_clr = 1'b0;
    endtask

    task automatic handshake();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("rsp_valid_after_hs", bus.rsp_valid, 1'b0);
    endtask

    task automatic single_op(input string tn, input int p, input logic [31:0] x,
                             input logic [31:0] y, input logic [31:0] z,
                             input logic [31:0] er, input logic [4:0] ef,
                             input logic [4:0] eacc, input int clr_at);
        int n;
        load(p, x, y, z);
        wait_accept(p);
        wait_rsp(clr_at, n);
        chk({tn, "_latency"}, n, 9);
        chk({tn, "_rslt"}, bus.rsp_rslt, er);
        chk({tn, "_flag"}, bus.rsp_flag, ef);
        chk({tn, "_id"}, bus.rsp_id, p);
        chk({tn, "_acc"}, bus.flag_acc, eacc);
        handshake();
    endtask

    // ---------------- stimulus ----------------
    int got[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    logic [31:0] snap;
    int n;

    initial begin
        bus.req_valid = '0;
        bus.req_x = '0;
        bus.req_y = '0;
        bus.req_z = '0;
        bus.rsp_ready = 1'b0;
        bus.flag_clr  = 1'b0;
        model_reset();

        // reset state, with requests pending to show ready stays low
        bus.req_valid = 4'b1111;
        repeat (2) tick();
        chk("rst_req_ready", bus.req_ready, 4'b0000);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_flag_acc", bus.flag_acc, 5'b00000);
        chk("rst_fu_req", bus.fu_req, 1'b0);
        bus.req_valid = '0;
        do_reset();

        // 1: basic op
        single_op("basic", 0, 32'h3FC00000, 32'h40000000, 32'h3E800000,
                  32'h40500000, 5'b00000, 5'b00000, 0);

        // 2: fairness with all requesters held valid
        do_reset();
        for (int p = 0; p < NREQ; p++)
            load(p, 32'h40000000, (p == 0) ? 32'h3F800000 : (p == 1) ? 32'h40000000 :
                 (p == 2) ? 32'h40400000 : 32'h40800000, 32'h00000000);
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b1111;
        got.delete();
        for (int c = 0; c < 200 && got.size() < 5; c++) begin
            @(negedge clk);
            for (int k = 0; k < NREQ; k++)
                if (bus.req_ready[k] && bus.req_valid[k]) got.push_back(k);
            tick();
            if (got.size() == 5) bus.req_valid = '0;
        end
        bus.req_valid = '0;
        chk("fair_count", got.size(), 5);
        for (int i = 0; i < got.size() && i < 5; i++) chk("fair_order", got[i], exp_order[i]);
        for (int c = 0; c < 40 && bus.busy; c++) tick();
        chk("fair_drain", bus.busy, 1'b0);
        bus.rsp_ready = 1'b0;

        // 3: invalid operation
        bus.flag_clr = 1'b1;
        tick();
        bus.flag_clr = 1'b0;
        single_op("invalid", 2, 32'h7F800000, 32'h00000000, 32'h00000000,
                  32'hFFC00000, 5'b10000, 5'b10000, 0);

        // 4: overflow with flag_clr during capture
        single_op("ovf_clr", 1, 32'h7F000000, 32'h7F000000, 32'h00000000,
                  32'h7F800000, 5'b00101, 5'b00101, 8);

        // 5: backpressure with another requester waiting
        load(3, 32'h40000000, 32'h40400000, 32'h00000000);
        load(0, 32'h40000000, 32'h3F800000, 32'h00000000);
        wait_accept(3);
        bus.req_valid[0] = 1'b1;
        wait_rsp(0, n);
        chk("bp_latency", n, 9);
        snap = bus.rsp_rslt;
        chk("bp_rslt", snap, 32'h40C00000);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_hold_valid", bus.rsp_valid, 1'b1);
            chk("bp_hold_rslt", bus.rsp_rslt, 32'h40C00000);
            chk("bp_hold_id", bus.rsp_id, 3);
            chk("bp_no_grant", bus.req_ready, 4'b0000);
        end
        handshake();
        wait_accept(0);
        wait_rsp(0, n);
        chk("bp_next_rslt", bus.rsp_rslt, 32'h40000000);
        chk("bp_next_id", bus.rsp_id, 0);
        handshake();

        // 6: reset in RUN with cnt=3
        load(0, 32'h3FC00000, 32'h40000000, 32'h3E800000);
        wait_accept(0);
        repeat (4) tick();
        bus.req_valid = 4'b0010;
        reset = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_req_ready", bus.req_ready, 4'b0000);
        chk("mid_rst_fu_req", bus.fu_req, 1'b0);
        chk("mid_rst_fu_x", bus.fu_x, 32'h0);
        chk("mid_rst_fu_y", bus.fu_y, 32'h0);
        chk("mid_rst_fu_z", bus.fu_z, 32'h0);
        chk("mid_rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("mid_rst_rsp_id", bus.rsp_id, 0);
        chk("mid_rst_rsp_rslt", bus.rsp_rslt, 32'h0);
        chk("mid_rst_rsp_flag", bus.rsp_flag, 5'b0);
        chk("mid_rst_busy", bus.busy, 1'b0);
        chk("mid_rst_flag_acc", bus.flag_acc, 5'b0);
        bus.req_valid = '0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        single_op("after_rst", 0, 32'h3FC00000, 32'h40000000, 32'h3E800000,
                  32'h40500000, 5'b00000, 5'b00000, 0);

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
